// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- stall/flush controller for the 5-stage pipeline.
//
// Produces per-stage register enables and flush/bubble controls from four
// sources: data-memory wait (highest priority), taken branch, debug
// halt/drain, and load-use hazard. All controls are combinational from the
// current state and inputs; halt_ack and mem_timeout are registered.
//
// Optional feature macro: PIPE_CTRL_PERF_EN adds the stall_cycles and
// flush_count saturating performance counters (ports absent otherwise).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   id_rs1/id_rs2         source registers of the instruction in ID
//   id_uses_rs1/rs2       the corresponding source is actually read
//   ex_mem_read, ex_rd    EX-stage load flag and destination register
//   ex_branch_taken       branch/jump in EX resolved taken
//   mem_req, mem_ready    data-memory handshake from MEM
//   halt_req              debug halt request (level)
//   *_en                  pipeline register enables (PC .. MEM/WB)
//   if_id_flush/id_ex_flush  load NOP/bubble into IF/ID, ID/EX
//   mem_wb_bubble         MEM/WB loads reg_write=0
//   halt_ack              pipeline drained and halted
//   mem_timeout           sticky memory-wait error
//   stall_cycles, flush_count  perf counters (PIPE_CTRL_PERF_EN only)
//   fsm_state             current controller state, for observation
//
// Memory handshake: an access is outstanding in any cycle with mem_req=1;
// it completes in the cycle mem_ready=1. A cycle with mem_req=1 and
// mem_ready=0 is a wait cycle and freezes PC..EX/MEM while MEM/WB takes a
// bubble.
module pipe_ctrl #(
  parameter int REGADDR_WIDTH = 4,
  parameter int DRAIN_CYCLES  = 3,
  parameter int WAIT_WIDTH    = 8,
  parameter int MAX_WAIT      = 255,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REGADDR_WIDTH-1:0] id_rs1,
  input  logic [REGADDR_WIDTH-1:0] id_rs2,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic                     ex_mem_read,
  input  logic [REGADDR_WIDTH-1:0] ex_rd,
  input  logic                     ex_branch_taken,
  input  logic                     mem_req,
  input  logic                     mem_ready,
  input  logic                     halt_req,
  output logic                     pc_en,
  output logic                     if_id_en,
  output logic                     id_ex_en,
  output logic                     ex_mem_en,
  output logic                     mem_wb_en,
  output logic                     if_id_flush,
  output logic                     id_ex_flush,
  output logic                     mem_wb_bubble,
  output logic                     halt_ack,
  output logic                     mem_timeout,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_WIDTH-1:0]     stall_cycles,
  output logic [CNT_WIDTH-1:0]     flush_count,
`endif
  output logic [1:0]               fsm_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0]        DRAIN_LOAD = DCW'(DRAIN_CYCLES);
  localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT = WAIT_WIDTH'(MAX_WAIT);

  if (DRAIN_CYCLES < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("pipe_ctrl: DRAIN_CYCLES and CNT_WIDTH must be at least 1");
  end

  state_t                state;
  state_t                ret_state;
  state_t                eff_state;
  logic [DCW-1:0]        drain_cnt;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic                  mem_stall;
  logic                  load_use;

  assign fsm_state = state;

  // MEM_WAIT is transparent once the stall clears: the cycle in which
  // mem_ready arrives behaves exactly like the state it will return to, so
  // a stall of N cycles delays drain/halt by exactly N cycles and a pending
  // load-use hazard is still honoured.
  always_comb begin
    mem_stall = mem_req & ~mem_ready;
    load_use  = ex_mem_read && (ex_rd != '0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));
    eff_state = (state == MEM_WAIT) ? ret_state : state;

    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;

    if (mem_stall) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // PC still loads the target, so a halt resumes at the branch target.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (eff_state == DRAIN || eff_state == HALTED ||
                 (eff_state == RUN && load_use)) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      ret_state   <= RUN;
      drain_cnt   <= '0;
      wait_cnt    <= '0;
      halt_ack    <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      // Consecutive-wait counter; the timeout fires on the stall cycle after
      // the counter has already reached the limit.
      if (mem_stall) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt >= WAIT_LIMIT) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      case (state)
        HALTED: begin
          if (!halt_req) begin
            state    <= RUN;
            halt_ack <= 1'b0;
          end
        end
        default: begin
          if (mem_stall) begin
            state <= MEM_WAIT;
            if (state != MEM_WAIT) ret_state <= state;
          end else if (eff_state == RUN) begin
            if (halt_req) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end else begin
              state <= RUN;
            end
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
            if (drain_cnt == DCW'(1)) begin
              state    <= HALTED;
              halt_ack <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && (state == RUN || state == MEM_WAIT) && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (if_id_flush && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by randomized traffic,
// all compared against a phase-level reference model (run / drain / halted
// plus a drain budget and a consecutive-stall run length).
module tb_pipe_ctrl;
  localparam int RW = 4;
  localparam int DC = 3;
  localparam int WW = 8;
  localparam int MW = 4;
  localparam int CW = 16;

  localparam int PH_RUN   = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_HALT  = 2;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic          mem_req, mem_ready, halt_req;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, mem_wb_bubble, halt_ack, mem_timeout;
  logic [1:0]    fsm_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [CW-1:0] stall_cycles, flush_count;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(
    .REGADDR_WIDTH(RW), .DRAIN_CYCLES(DC), .WAIT_WIDTH(WW),
    .MAX_WAIT(MW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_bubble(mem_wb_bubble), .halt_ack(halt_ack),
    .mem_timeout(mem_timeout),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .fsm_state(fsm_state)
  );

  // ---------------- reference model ----------------
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;
  int   m_phase = PH_RUN;
  int   m_left  = 0;
  int   m_run   = 0;
  logic m_timeout = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
  int   m_stalls = 0;
  int   m_flushes = 0;
  logic m_in_wait = 1'b0;
`endif

  function automatic logic [7:0] obs_ctrl();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, mem_wb_bubble};
  endfunction

  // Expected {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id_flush, id_ex_flush, bubble}.
  function automatic logic [7:0] model_ctrl();
    logic ms, lu;
    ms = mem_req && !mem_ready;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (ms) return 8'h09;              // freeze front, bubble MEM/WB
    if (ex_branch_taken) return 8'hFE; // everything moves, flush IF/ID and ID/EX
    if (m_phase != PH_RUN || lu) return 8'h3A; // hold PC/IF, bubble into EX
    return 8'hF8;
  endfunction

  task automatic model_update();
    logic ms;
    logic [7:0] e;
    ms = mem_req && !mem_ready;
    e  = model_ctrl();
    if (reset) begin
      m_phase = PH_RUN; m_left = 0; m_run = 0; m_timeout = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
      m_stalls = 0; m_flushes = 0; m_in_wait = 1'b0;
`endif
    end else begin
`ifdef PIPE_CTRL_PERF_EN
      if (!e[7] && (m_phase == PH_RUN || m_in_wait) && m_stalls < (1 << CW) - 1) m_stalls++;
      if (e[2] && m_flushes < (1 << CW) - 1) m_flushes++;
      m_in_wait = ms && (m_phase != PH_HALT);
`endif
      if (ms) begin
        m_run++;
        if (m_run > MW) m_timeout = 1'b1;
      end else begin
        m_run = 0;
      end
      if (m_phase == PH_HALT) begin
        if (!halt_req) m_phase = PH_RUN;
      end else if (!ms) begin
        if (m_phase == PH_RUN) begin
          if (halt_req) begin m_phase = PH_DRAIN; m_left = DC; end
        end else begin
          m_left--;
          if (m_left == 0) m_phase = PH_HALT;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: combinational controls checked before the edge, registered
  // outputs checked just after it. Entered and left at the falling edge.
  task automatic cycle(input string tag);
    #1 check({tag, "_ctrl"}, 16'(obs_ctrl()), 16'(model_ctrl()));
    @(posedge clk);
    model_update();
    #1;
    check({tag, "_ack"}, 16'(halt_ack), 16'(m_phase == PH_HALT));
    check({tag, "_tmo"}, 16'(mem_timeout), 16'(m_timeout));
`ifdef PIPE_CTRL_PERF_EN
    check({tag, "_stalls"}, 16'(stall_cycles), 16'(m_stalls));
    check({tag, "_flushes"}, 16'(flush_count), 16'(m_flushes));
`endif
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  task automatic set_idle();
    reset = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_rd = '0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
  endtask

  task automatic set_load_use(input logic [RW-1:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = 4'd5; id_uses_rs1 = 1'b1;
    id_rs2 = 4'd9; id_uses_rs2 = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int edges;
    int burst;
    set_idle();
    reset = 1'b1;
    @(posedge clk); model_update(); @(negedge clk);
    cycle("reset");
    reset = 1'b0;
    cycle("idle");
    check("idle_all_en", 16'(obs_ctrl()), 16'h00F8);

    // Load-use on rs1 (rs2 unused): single bubble, then clears.
    set_load_use(4'd5);
    #1 check("lu_pc_if_flush", 16'({pc_en, if_id_en, id_ex_flush}), 16'b001);
    cycle("lu");
    set_idle();
    cycle("lu_clear");
    set_load_use(4'd0);
    #1 check("lu_rd0_pc_en", 16'(pc_en), 16'd1);
    cycle("lu_rd0");
    set_load_use(4'd7);
    id_rs2 = 4'd7; id_uses_rs2 = 1'b1;
    cycle("lu_rs2");

    // Branch wins over load-use.
    set_load_use(4'd5);
    ex_branch_taken = 1'b1;
    #1 check("br_lu", 16'({pc_en, if_id_flush, id_ex_flush}), 16'b111);
    cycle("br_lu");
    set_idle();

    // Four-cycle memory wait, no timeout at the limit itself.
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check("mw4_exmem_bubble", 16'({ex_mem_en, mem_wb_bubble}), 16'b01);
      cycle("mw4");
    end
    mem_ready = 1'b1;
    cycle("mw4_done");
    set_idle();
    cycle("mw4_after");
    check("mw4_no_timeout", 16'(mem_timeout), 16'd0);

    // Halt with no stalls: ack on the 4th edge counting the sampling edge.
    halt_req = 1'b1;
    edges = 0;
    while (!halt_ack && edges < 20) begin cycle("halt"); edges++; end
    check("halt_latency", 16'(edges), 16'(DC + 1));
    cycle("halted_hold");
    halt_req = 1'b0;
    cycle("resume");
    check("resume_ack", 16'(halt_ack), 16'd0);

    // Two-cycle memory wait inside drain delays ack by exactly two.
    halt_req = 1'b1;
    cycle("dstall_e0");
    mem_req = 1'b1; mem_ready = 1'b0;
    cycle("dstall_w1");
    cycle("dstall_w2");
    mem_req = 1'b0;
    edges = 3;
    while (!halt_ack && edges < 20) begin cycle("dstall"); edges++; end
    check("dstall_latency", 16'(edges), 16'(DC + 1 + 2));

    // Branch while halted: target loads, flushes asserted.
    ex_branch_taken = 1'b1;
    cycle("halt_br");
    ex_branch_taken = 1'b0;

    // Reset while halted.
    reset = 1'b1; halt_req = 1'b0;
    cycle("rst_halt");
    check("rst_halt_ack", 16'(halt_ack), 16'd0);
    reset = 1'b0;
    cycle("post_rst");
    check("post_rst_ctrl", 16'(obs_ctrl()), 16'h00F8);

    // Five-cycle wait exceeds MAX_WAIT=4: timeout sticks afterwards.
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle("mw5");
    set_idle();
    cycle("mw5_after");
    cycle("mw5_after2");
    check("timeout_sticky", 16'(mem_timeout), 16'd1);
    reset = 1'b1;
    cycle("rst_tmo");
    check("timeout_cleared", 16'(mem_timeout), 16'd0);
    reset = 1'b0;

    // Randomized traffic.
    burst = 0;
    for (int n = 0; n < 500; n++) begin
      id_rs1 = RW'($urandom_range(0, 3));
      id_rs2 = RW'($urandom_range(0, 3));
      ex_rd  = RW'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      if (burst > 0) begin
        mem_req = 1'b1; mem_ready = 1'b0; burst--;
      end else begin
        mem_req   = ($urandom_range(0, 3) == 0);
        mem_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 49) == 0) burst = 6;
      end
      if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
      reset = ($urandom_range(0, 99) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
